// File: rtl/branch_prediction_unit.sv
// Dynamic branch predictor for the fetch stage.
// A direct-mapped table of 2-bit saturating counters decides the direction. A tagged BTB supplies
// the taken target. Lookup is combinational from registered state. Resolved branches from execute
// train both tables on the rising edge.
module branch_prediction_unit #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic        branch_resolved,
  input  logic        actual_taken,
  input  logic [63:0] branch_pc,
  input  logic [63:0] branch_target_resolved,
  output logic        predict_taken,
  output logic [63:0] target_pc
);

  localparam int unsigned TagBits = 64 - INDEX_BITS - 2;
  localparam int unsigned Entries = 1 << INDEX_BITS;

  // Counter encoding: 00 strongly not taken .. 11 strongly taken.
  localparam logic [1:0] CtrSnt = 2'b00;
  localparam logic [1:0] CtrWnt = 2'b01;
  localparam logic [1:0] CtrSt  = 2'b11;

  // Prediction state
  logic [1:0]         ctr_q        [Entries];
  logic               btb_valid_q  [Entries];
  logic [TagBits-1:0] btb_tag_q    [Entries];
  logic [63:0]        btb_target_q [Entries];

  // Lookup side
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TagBits-1:0]    lk_tag;
  logic                  lk_hit;
  logic                  lk_taken;

  // Update side
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TagBits-1:0]    upd_tag;
  logic [1:0]            upd_ctr_cur;
  logic [1:0]            upd_ctr_d;

  // The word-offset bits of the resolved PC carry no information for the tables.
  logic unused_branch_pc_low;
  assign unused_branch_pc_low = ^branch_pc[1:0];

  // Split the fetch and resolved PCs into table index and tag.
  always_comb begin
    lk_idx  = pc[INDEX_BITS+1:2];
    lk_tag  = pc[63:INDEX_BITS+2];
    upd_idx = branch_pc[INDEX_BITS+1:2];
    upd_tag = branch_pc[63:INDEX_BITS+2];
  end

  // Lookup: a BTB tag mismatch vetoes the (untagged, possibly aliased) counter.
  always_comb begin
    lk_hit   = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr_q[lk_idx][1];
  end

  // Outputs: while reset is asserted, force the not-taken, sequential prediction.
  always_comb begin
    predict_taken = reset && lk_taken;
    target_pc     = predict_taken ? btb_target_q[lk_idx] : pc + 64'd4;
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    upd_ctr_cur = ctr_q[upd_idx];
    upd_ctr_d   = upd_ctr_cur;
    if (actual_taken) begin
      if (upd_ctr_cur != CtrSt) begin
        upd_ctr_d = upd_ctr_cur + 2'd1;
      end
    end else if (upd_ctr_cur != CtrSnt) begin
      upd_ctr_d = upd_ctr_cur - 2'd1;
    end
  end

  // Counter table: reset to weakly not taken, trained on every resolution.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= CtrWnt;
      end
    end else if (branch_resolved) begin
      ctr_q[upd_idx] <= upd_ctr_d;
    end
  end

  // BTB: only taken resolutions allocate or replace an entry.
  // A replacement deliberately leaves the shared counter alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Entries; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else if (branch_resolved && actual_taken) begin
      btb_valid_q[upd_idx]  <= 1'b1;
      btb_tag_q[upd_idx]    <= upd_tag;
      btb_target_q[upd_idx] <= branch_target_resolved;
    end
  end

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Randomized scoreboard bench for branch_prediction_unit.
// The driver predicts each cycle's outputs from a table model and queues them. The monitor
// compares the queued values against the DUT outputs in the same cycle.
module tb_branch_prediction_unit;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic        branch_resolved;
  logic        actual_taken;
  logic [63:0] branch_pc;
  logic [63:0] branch_target_resolved;
  logic        predict_taken;
  logic [63:0] target_pc;

  branch_prediction_unit #(
    .INDEX_BITS(6)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .pc                    (pc),
    .branch_resolved       (branch_resolved),
    .actual_taken          (actual_taken),
    .branch_pc             (branch_pc),
    .branch_target_resolved(branch_target_resolved),
    .predict_taken         (predict_taken),
    .target_pc             (target_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  // Reference model: 64 entries, counters as plain integers 0..3.
  int unsigned     m_ctr   [64];
  bit              m_valid [64];
  longint unsigned m_tag   [64];
  longint unsigned m_tgt   [64];

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i]   = 1;
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
    end
  endfunction

  function automatic int unsigned idx_of(longint unsigned a);
    return int'((a / 4) % 64);
  endfunction

  function automatic longint unsigned tag_of(longint unsigned a);
    return a / 256;
  endfunction

  // One cycle: drive inputs, queue the expected outputs, then advance the model.
  task automatic step(input string name, input bit rst_v, input longint unsigned p,
                      input bit res, input bit tk, input longint unsigned bpc,
                      input longint unsigned tgt);
    exp_t        e;
    int unsigned i;
    @(negedge clk);
    reset                  = rst_v;
    pc                     = p;
    branch_resolved        = res;
    actual_taken           = tk;
    branch_pc              = bpc;
    branch_target_resolved = tgt;
    if (!rst_v) model_reset();
    i        = idx_of(p);
    e.name   = name;
    e.pc     = p;
    e.taken  = rst_v && m_valid[i] && (m_tag[i] == tag_of(p)) && (m_ctr[i] >= 2);
    e.target = e.taken ? m_tgt[i] : p + 64'd4;
    exp_q.push_back(e);
    if (rst_v && res) begin
      i = idx_of(bpc);
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
        m_valid[i] = 1;
        m_tag[i]   = tag_of(bpc);
        m_tgt[i]   = tgt;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i] = m_ctr[i] - 1;
      end
    end
  endtask

  // Monitor: compare outputs a few time units after the inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (predict_taken !== e.taken) begin
          failures++;
          $display("FAIL %s predict_taken pc=%h got=%b want=%b", e.name, e.pc, predict_taken,
                   e.taken);
        end
        checks++;
        if (target_pc !== e.target) begin
          failures++;
          $display("FAIL %s target_pc pc=%h got=%h want=%h", e.name, e.pc, target_pc, e.target);
        end
      end
    end
  end

  initial begin
    longint unsigned rp, rb, rt;
    int              wait_cycles;
    reset = 1'b0;
    pc = 64'h0;
    branch_resolved = 1'b0;
    actual_taken = 1'b0;
    branch_pc = 64'h0;
    branch_target_resolved = 64'h0;
    model_reset();

    // Outputs held in reset, even with a resolution presented.
    step("in_reset", 0, 64'h100, 0, 0, 0, 0);
    step("in_reset_upd", 0, 64'h100, 1, 1, 64'h100, 64'h200);

    step("after_reset", 1, 64'h100, 0, 0, 0, 0);
    step("taken_upd", 1, 64'h100, 1, 1, 64'h100, 64'h200);
    step("after_taken", 1, 64'h100, 0, 0, 0, 0);
    step("nt_upd", 1, 64'h100, 1, 0, 64'h100, 0);
    step("after_nt", 1, 64'h100, 0, 0, 0, 0);
    step("retrain", 1, 64'h100, 1, 1, 64'h100, 64'h200);
    step("alias_tag", 1, 64'h200, 0, 0, 0, 0);
    step("hit_again", 1, 64'h100, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("sat_up", 1, 64'h100, 1, 1, 64'h100, 64'h200);
    step("saturated", 1, 64'h100, 0, 0, 0, 0);
    step("sat_dn1", 1, 64'h100, 1, 0, 64'h100, 0);
    step("one_nt", 1, 64'h100, 1, 0, 64'h100, 0);
    step("two_nt", 1, 64'h100, 0, 0, 0, 0);
    step("low_bits", 1, 64'h103, 0, 0, 0, 0);
    step("replace", 1, 64'h200, 1, 1, 64'h200, 64'h300);
    step("old_tag", 1, 64'h100, 0, 0, 0, 0);
    step("new_tag", 1, 64'h200, 0, 0, 0, 0);
    step("wrap", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
    step("mid_reset", 0, 64'h100, 1, 1, 64'h100, 64'h200);
    step("post_reset", 1, 64'h100, 0, 0, 0, 0);

    // Random traffic over a few tags and indices so hits and aliases are frequent.
    for (int n = 0; n < 3000; n++) begin
      rp = {54'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'b000, 2'($urandom)};
      rb = {54'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'b000, 2'($urandom)};
      rt = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) begin
        step("rand_reset", 0, rp, 1, 1, rb, rt);
      end else begin
        step("rand", 1, rp, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), rb, rt);
      end
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    #4;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain queue_left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
